// File: rtl/ysyx_24110015_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_lsu
//
// Multi-cycle load/store unit between the execute stage and the memory bus
// adapter. It accepts one request at a time and checks alignment and funct3
// at accept time. Legal accesses go onto a valid/ready request bus and wait
// for the response. Sub-word data is steered to and from the selected byte
// lanes. A watchdog counter turns a stalled bus access into an access fault.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_ready is high only when idle
//   in_wen, in_func3    store/load select and RISC-V funct3
//   in_addr, in_wdata   byte address and store data (low bits significant)
//   mem_req_*           bus request: word-aligned address, lane-shifted
//                       write data and byte strobes (strobes 0 for reads)
//   mem_rsp_valid/rdata bus response, sampled only while waiting for it
//   out_valid/out_ready downstream handshake for the result
//   out_rdata           extended load data; 0 for stores and exceptions
//   out_exc, out_cause  exception flag and mcause (4/5 load, 6/7 store)
//
// Every output is decoded from registered state. In reset and idle, all
// outputs read zero except in_ready.
// ---------------------------------------------------------------------------
module ysyx_24110015_lsu #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_wen,
    input  logic [2:0]          in_func3,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_wen,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_rdata,
    output logic                out_exc,
    output logic [3:0]          out_cause
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // The counter value seen in the last allowed REQ/WAIT cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit TO_EN = (TIMEOUT != 0);

    localparam logic [3:0] CAUSE_LD_MISAL = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISAL = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  to_cnt;

    // Request fields captured at accept
    logic              wen_p0;
    logic [2:0]        func3_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;

    // Result fields presented in DONE
    logic [DATA_W-1:0] rdata_p1;
    logic              exc_p1;
    logic [3:0]        cause_p1;
    logic              vld_p1;

    logic              accept;
    logic              timeout_hit;
    logic              rsp_take;
    logic              req_wr;
    logic [OFF_W-1:0]  off_p0;

    // Loads: LB/LH/LW/LBU/LHU (0,1,2,4,5); stores: SB/SH/SW (0,1,2).
    function automatic logic func3_legal(input logic wen, input logic [2:0] f3);
        logic ok;
        if (wen) ok = (f3 <= 3'd2);
        else     ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [OFF_W-1:0] off);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = off[0];
            2'b10:   bad = (off != '0);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [NB-1:0] store_strb(input logic [2:0] f3, input logic [OFF_W-1:0] off);
        logic [NB-1:0] base;
        case (f3[1:0])
            2'b00:   base = NB'(1);
            2'b01:   base = NB'(3);
            default: base = '1;
        endcase
        return base << off;
    endfunction

    function automatic logic [DATA_W-1:0] store_data(input logic [2:0] f3,
                                                     input logic [DATA_W-1:0] wd,
                                                     input logic [OFF_W-1:0] off);
        logic [DATA_W-1:0] lane;
        case (f3[1:0])
            2'b00:   lane = DATA_W'(wd[7:0]);
            2'b01:   lane = DATA_W'(wd[15:0]);
            default: lane = wd;
        endcase
        return lane << {off, 3'b000};
    endfunction

    // Bring the addressed lane down to bit 0, then sign- or zero-extend it.
    function automatic logic [DATA_W-1:0] load_extract(input logic [2:0] f3,
                                                       input logic [DATA_W-1:0] rd,
                                                       input logic [OFF_W-1:0] off);
        logic        [DATA_W-1:0] sh;
        logic signed [7:0]        b;
        logic signed [15:0]       h;
        logic signed [DATA_W-1:0] ext;
        sh = rd >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            3'b000:  ext = DATA_W'(b);
            3'b001:  ext = DATA_W'(h);
            3'b100:  ext = DATA_W'(sh[7:0]);
            3'b101:  ext = DATA_W'(sh[15:0]);
            default: ext = sh;
        endcase
        return $unsigned(ext);
    endfunction

    assign accept      = in_valid && (state == S_IDLE);
    assign timeout_hit = TO_EN && (to_cnt == CNT_LAST);
    assign rsp_take    = (state == S_WAIT) && mem_rsp_valid && !timeout_hit;
    assign off_p0      = addr_p0[OFF_W-1:0];

    // Control: FSM, watchdog and exception status
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            to_cnt   <= '0;
            exc_p1   <= 1'b0;
            cause_p1 <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        to_cnt <= '0;
                        if (!func3_legal(in_wen, in_func3)) begin
                            exc_p1   <= 1'b1;
                            cause_p1 <= in_wen ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                            state    <= S_DONE;
                        end else if (misaligned(in_func3, in_addr[OFF_W-1:0])) begin
                            exc_p1   <= 1'b1;
                            cause_p1 <= in_wen ? CAUSE_ST_MISAL : CAUSE_LD_MISAL;
                            state    <= S_DONE;
                        end else begin
                            exc_p1   <= 1'b0;
                            cause_p1 <= '0;
                            state    <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    to_cnt <= to_cnt + 1'b1;
                    // A timeout wins over a handshake in the same cycle.
                    if (timeout_hit) begin
                        exc_p1   <= 1'b1;
                        cause_p1 <= wen_p0 ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                        state    <= S_DONE;
                    end else if (mem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (timeout_hit) begin
                        exc_p1   <= 1'b1;
                        cause_p1 <= wen_p0 ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                        state    <= S_DONE;
                    end else if (mem_rsp_valid) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Data: request capture and response steering (no reset needed)
    always_ff @(posedge clk) begin
        if (accept) begin
            wen_p0   <= in_wen;
            func3_p0 <= in_func3;
            addr_p0  <= in_addr;
            wdata_p0 <= in_wdata;
        end
        if (rsp_take) begin
            rdata_p1 <= wen_p0 ? '0 : load_extract(func3_p0, mem_rsp_rdata, off_p0);
        end
    end

    assign req_wr        = (state == S_REQ) && wen_p0;
    assign vld_p1        = (state == S_DONE);

    assign in_ready      = (state == S_IDLE);
    assign mem_req_valid = (state == S_REQ);
    assign mem_req_wen   = req_wr;
    assign mem_req_addr  = (state == S_REQ) ? {addr_p0[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_req_wdata = req_wr ? store_data(func3_p0, wdata_p0, off_p0) : '0;
    assign mem_req_wstrb = req_wr ? store_strb(func3_p0, off_p0) : '0;

    assign out_valid     = vld_p1;
    assign out_rdata     = (vld_p1 && !exc_p1) ? rdata_p1 : '0;
    assign out_exc       = vld_p1 && exc_p1;
    assign out_cause     = vld_p1 ? cause_p1 : '0;

endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ysyx_24110015_lsu (TIMEOUT=8). Directed accesses
// push their expected bus request and result into queues. Two monitors pop
// and compare those entries whenever a request or result handshake occurs.
// ---------------------------------------------------------------------------
module tb_ysyx_24110015_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [2:0]  in_func3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_exc;
    logic [3:0]  out_cause;

    ysyx_24110015_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_wen       (in_wen),
        .in_func3     (in_func3),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_wen  (mem_req_wen),
        .mem_req_addr (mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rdata    (out_rdata),
        .out_exc      (out_exc),
        .out_cause    (out_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        logic [3:0]  cause;
    } out_t;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    out_t out_q[$];
    req_t req_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_out(input logic [31:0] rdata, input logic exc, input logic [3:0] cause);
        out_t e;
        e.rdata = rdata;
        e.exc   = exc;
        e.cause = cause;
        out_q.push_back(e);
    endtask

    task automatic exp_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
        req_t r;
        r.wen   = wen;
        r.addr  = addr;
        r.wdata = wdata;
        r.wstrb = wstrb;
        req_q.push_back(r);
    endtask

    // Result monitor
    always @(negedge clk) begin : mon_out
        out_t e;
        if (!rst && out_valid && out_ready) begin
            if (out_q.size() == 0) begin
                check("out_unexpected", 32'(out_valid), 32'd0);
            end else begin
                e = out_q.pop_front();
                check("out_rdata", out_rdata, e.rdata);
                check("out_exc", 32'(out_exc), 32'(e.exc));
                check("out_cause", 32'(out_cause), 32'(e.cause));
            end
        end
    end

    // Bus request monitor
    always @(negedge clk) begin : mon_req
        req_t r;
        if (!rst && mem_req_valid && mem_req_ready) begin
            if (req_q.size() == 0) begin
                check("req_unexpected", 32'(mem_req_valid), 32'd0);
            end else begin
                r = req_q.pop_front();
                check("req_wen", 32'(mem_req_wen), 32'(r.wen));
                check("req_addr", mem_req_addr, r.addr);
                check("req_wstrb", 32'(mem_req_wstrb), 32'(r.wstrb));
                if (r.wen) check("req_wdata", mem_req_wdata, r.wdata);
            end
        end
    end

    // Called just after a posedge with the DUT idle; returns just after the
    // accepting edge (cycle T+1).
    task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        in_valid = 1'b1;
        in_wen   = wen;
        in_func3 = f3;
        in_addr  = addr;
        in_wdata = wd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // One access against a bus that is always ready and answers one cycle
    // after the request handshake; checks the accept-to-out_valid latency.
    task automatic access(input string tag, input logic wen, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rsp, input int exp_lat);
        int lat;
        bit hs;
        lat = 0;
        issue(wen, f3, addr, wd);
        mem_req_ready = 1'b1;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (out_valid) lat = c;
            hs = mem_req_valid && mem_req_ready;
            @(posedge clk);
            #1;
            mem_rsp_valid = hs;
            mem_rsp_rdata = rsp;
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 32'(ok), 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin : stim
        int vcnt;
        int first;
        int bad;
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_wen        = 1'b0;
        in_func3      = 3'd0;
        in_addr       = 32'h0;
        in_wdata      = 32'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        out_ready     = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_out_rdata", out_rdata, 32'd0);
        check("rst_out_exc", 32'(out_exc), 32'd0);
        check("rst_out_cause", 32'(out_cause), 32'd0);
        check("rst_req_addr", mem_req_addr, 32'd0);
        check("rst_req_wstrb", 32'(mem_req_wstrb), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Aligned loads with lane extraction
        exp_req(1'b0, 32'h8000_0004, 32'h0, 4'h0);
        exp_out(32'hDEAD_BEEF, 1'b0, 4'd0);
        access("lw", 1'b0, 3'd2, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 3);

        exp_req(1'b0, 32'h8000_0000, 32'h0, 4'h0);
        exp_out(32'hFFFF_FF80, 1'b0, 4'd0);
        access("lb3", 1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'h80FF_1234, 3);

        exp_req(1'b0, 32'h8000_0000, 32'h0, 4'h0);
        exp_out(32'h0000_0080, 1'b0, 4'd0);
        access("lbu3", 1'b0, 3'd4, 32'h8000_0003, 32'h0, 32'h80FF_1234, 3);

        exp_req(1'b0, 32'h8000_0000, 32'h0, 4'h0);
        exp_out(32'h0000_0012, 1'b0, 4'd0);
        access("lb1", 1'b0, 3'd0, 32'h8000_0001, 32'h0, 32'h80FF_1234, 3);

        exp_req(1'b0, 32'h8000_0000, 32'h0, 4'h0);
        exp_out(32'hFFFF_80FF, 1'b0, 4'd0);
        access("lh2", 1'b0, 3'd1, 32'h8000_0002, 32'h0, 32'h80FF_1234, 3);

        exp_req(1'b0, 32'h8000_0000, 32'h0, 4'h0);
        exp_out(32'h0000_80FF, 1'b0, 4'd0);
        access("lhu2", 1'b0, 3'd5, 32'h8000_0002, 32'h0, 32'h80FF_1234, 3);

        // Stores: lane-shifted data and strobes, zero result
        exp_req(1'b1, 32'h8000_0000, 32'hABCD_0000, 4'b1100);
        exp_out(32'h0, 1'b0, 4'd0);
        access("sh2", 1'b1, 3'd1, 32'h8000_0002, 32'h0000_ABCD, 32'h1234_5678, 3);

        exp_req(1'b1, 32'h8000_0000, 32'h0000_A500, 4'b0010);
        exp_out(32'h0, 1'b0, 4'd0);
        access("sb1", 1'b1, 3'd0, 32'h8000_0001, 32'h1234_56A5, 32'h1234_5678, 3);

        exp_req(1'b1, 32'h8000_0008, 32'h1122_3344, 4'b1111);
        exp_out(32'h0, 1'b0, 4'd0);
        access("sw", 1'b1, 3'd2, 32'h8000_0008, 32'h1122_3344, 32'h0, 3);

        // Misaligned and illegal funct3: no bus request, result at T+1
        exp_out(32'h0, 1'b1, 4'd4);
        access("lw_mis", 1'b0, 3'd2, 32'h8000_0001, 32'h0, 32'h0, 1);
        exp_out(32'h0, 1'b1, 4'd4);
        access("lh_mis", 1'b0, 3'd1, 32'h8000_0003, 32'h0, 32'h0, 1);
        exp_out(32'h0, 1'b1, 4'd6);
        access("sw_mis", 1'b1, 3'd2, 32'h8000_0002, 32'h5555_5555, 32'h0, 1);
        exp_out(32'h0, 1'b1, 4'd6);
        access("sh_mis", 1'b1, 3'd1, 32'h8000_0001, 32'h5555_5555, 32'h0, 1);
        exp_out(32'h0, 1'b1, 4'd5);
        access("ld_f3_3", 1'b0, 3'd3, 32'h8000_0000, 32'h0, 32'h0, 1);
        exp_out(32'h0, 1'b1, 4'd5);
        access("ld_f3_6", 1'b0, 3'd6, 32'h8000_0000, 32'h0, 32'h0, 1);
        exp_out(32'h0, 1'b1, 4'd7);
        access("st_f3_4", 1'b1, 3'd4, 32'h8000_0000, 32'h0, 32'h0, 1);

        // Response during REQ is ignored; the one in WAIT is used
        exp_req(1'b0, 32'h8000_0018, 32'h0, 4'h0);
        exp_out(32'h55AA_55AA, 1'b0, 4'd0);
        issue(1'b0, 3'd2, 32'h8000_0018, 32'h0);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h55AA_55AA;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("ign_out_valid_t4", 32'(out_valid), 32'd1);
        wait_idle("ign");

        // Output stall: result held stable while out_ready is low
        exp_req(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        exp_out(32'h0123_4567, 1'b0, 4'd0);
        out_ready = 1'b0;
        issue(1'b0, 3'd2, 32'h8000_0010, 32'h0);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h0123_4567;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'hFFFF_FFFF;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!(out_valid && !in_ready && out_rdata == 32'h0123_4567 && !out_exc
                  && out_cause == 4'd0)) bad++;
            @(posedge clk);
            #1;
        end
        check("stall_unstable_cycles", 32'(bad), 32'd0);
        out_ready = 1'b1;
        wait_idle("stall");

        // Load timeout in REQ; a late response in DONE/IDLE is ignored
        exp_out(32'h0, 1'b1, 4'd5);
        out_ready = 1'b0;
        issue(1'b0, 3'd2, 32'h8000_0008, 32'h0);
        mem_req_ready = 1'b0;
        vcnt  = 0;
        first = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_req_valid) vcnt++;
            if (out_valid && first == 0) first = c;
            @(posedge clk);
            #1;
            mem_rsp_valid = (c == 9 || c == 10);
            mem_rsp_rdata = 32'hBAD0_BAD0;
        end
        mem_rsp_valid = 1'b0;
        check("to_ld_req_cycles", 32'(vcnt), 32'd8);
        check("to_ld_out_cycle", 32'(first), 32'd9);
        @(negedge clk);
        check("to_ld_hold_in_ready", 32'(in_ready), 32'd0);
        check("to_ld_hold_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle("to_ld");
        mem_rsp_valid = 1'b1;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("to_ld_late_rsp_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Store timeout in WAIT (request accepted, response never arrives)
        exp_req(1'b1, 32'h8000_000C, 32'hCAFE_F00D, 4'hF);
        exp_out(32'h0, 1'b1, 4'd7);
        issue(1'b1, 3'd2, 32'h8000_000C, 32'hCAFE_F00D);
        mem_req_ready = 1'b1;
        vcnt  = 0;
        first = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_req_valid) vcnt++;
            if (out_valid && first == 0) first = c;
            @(posedge clk);
            #1;
            mem_req_ready = 1'b0;
        end
        check("to_st_req_cycles", 32'(vcnt), 32'd1);
        check("to_st_out_cycle", 32'(first), 32'd9);
        wait_idle("to_st");

        // Reset asserted while waiting for a response
        exp_req(1'b0, 32'h8000_0014, 32'h0, 4'h0);
        issue(1'b0, 3'd2, 32'h8000_0014, 32'h0);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstw_in_ready", 32'(in_ready), 32'd1);
        check("rstw_out_valid", 32'(out_valid), 32'd0);
        check("rstw_req_valid", 32'(mem_req_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;

        // Recovery after reset
        exp_req(1'b0, 32'h8000_0020, 32'h0, 4'h0);
        exp_out(32'h1357_9BDF, 1'b0, 4'd0);
        access("lw_after_rst", 1'b0, 3'd2, 32'h8000_0020, 32'h0, 32'h1357_9BDF, 3);

        repeat (3) @(posedge clk);
        check("out_q_drained", 32'(out_q.size()), 32'd0);
        check("req_q_drained", 32'(req_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_24110015_lsu.md
Name: ysyx_24110015_lsu

Overview:
Multi-cycle load/store unit, the next generation of the EXU memory path. It replaces direct combinational memory calls with a valid/ready request/response bus. It sits between the execute stage (upstream handshake) and the memory/bus adapter (downstream). It adds sub-word lane steering, misalignment detection, a bus timeout with access-fault reporting, and parametrised data and address widths.

Parameters:
ADDR_W, 32, address width in bits.
DATA_W, 32, bus and register data width; only 32 is legal in this revision; lane logic is written generically over DATA_W/8 byte lanes.
TIMEOUT, 255, max cycles spent in REQ+WAIT before an access fault; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream request valid
in_ready  out  1  LSU can accept a request
in_wen  in  1  1=store, 0=load
in_func3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
in_addr  in  ADDR_W  byte address
in_wdata  in  DATA_W  store data (low bits significant)
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_req_wen  out  1  write request
mem_req_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
mem_req_wdata  out  DATA_W  lane-shifted write data
mem_req_wstrb  out  DATA_W/8  byte strobes; 0 for reads
mem_rsp_valid  in  1  read/write response valid
mem_rsp_rdata  in  DATA_W  word read data
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_rdata  out  DATA_W  extended load data; 0 for stores and exceptions
out_exc  out  1  exception flag
out_cause  out  4  mcause code: 4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault

Behaviour:
- Single clock domain. Reset is synchronous active-high. All state registers are updated on the posedge of clk.
- States are IDLE, REQ, WAIT, DONE. Reset sends the FSM to IDLE, and all outputs read 0 except in_ready, which reads 1.
- in_ready = (state==IDLE). An accept (in_valid && in_ready) latches wen, func3, addr and wdata.
- Accept-time checks:
  - Halfword access with addr[0]!=0, word access with addr[1:0]!=0, or an illegal func3 (load 3/6/7, store >=3) goes directly to DONE.
  - For these, out_exc=1, cause 4/6 for misaligned and 5/7 for illegal func3, and no bus request is issued.
  - Otherwise the FSM goes to REQ.
- REQ state:
  - mem_req_valid=1, with all mem_req_* fields held stable until mem_req_ready.
  - On handshake the FSM goes to WAIT.
  - wstrb is 0001/0011/1111 shifted left by addr[1:0].
  - wdata is the low byte/half/word shifted left by 8*addr[1:0].
- WAIT state:
  - mem_rsp_valid is sampled only in WAIT; a response seen in any other state is ignored. Minimum bus latency is therefore 1 cycle.
  - On a response the FSM goes to DONE.
  - For loads, the lane selected by addr[1:0] is extracted and then sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - For stores, out_rdata=0.
- Timeout:
  - A counter clears on accept and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT, the FSM goes to DONE with out_exc=1 and cause 5 (load) or 7 (store). mem_req_valid drops the same cycle.
  - A late response for the abandoned request is ignored.
- DONE state: out_valid=1 with data/exc/cause stable until out_ready, then the FSM returns to IDLE. There is one bubble cycle and no accept in DONE.
- Latency:
  - Accept at T, mem_req_valid at T+1.
  - With ready at T+1 and response at T+2, out_valid is at T+3.
  - A misaligned access gives out_valid at T+1.
- Reset mid-operation: the FSM returns to IDLE, mem_req_valid drops next edge, and the in-flight result is discarded.

Test Plan:
- LW at 0x80000004, ready=1, rsp 0xDEADBEEF after 1 cycle -> mem_req_addr=0x80000004, wstrb=0, out_valid at T+3, out_rdata=0xDEADBEEF, out_exc=0.
- LB at 0x80000003, rsp 0x80FF1234 -> out_rdata=0xFFFFFF80; the same access as LBU -> 0x00000080.
- SH at 0x80000002, wdata 0x0000ABCD -> wstrb=1100, mem_req_wdata=0xABCD0000, out_rdata=0.
- LW at 0x80000001 -> no mem_req_valid, out_valid at T+1, out_exc=1, cause=4; SW at 0x80000002 -> cause=6.
- TIMEOUT=8, mem_req_ready held 0 -> out_exc=1, cause=5 after 8 cycles in REQ; a response injected later is ignored and in_ready returns after out_ready.
- out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0. Assert rst during WAIT -> next cycle in_ready=1, out_valid=0, mem_req_valid=0.
